// File: rtl/cla_adder_pipe_if.sv
// Operand/result bundle for cla_adder_pipe: valid/ready on the input and the output side.
// The optional subtract control (sub) exists only when CLA_SUB_EN is defined.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

`ifdef CLA_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
`endif
endinterface

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder, WIDTH bits in GROUP-bit lookahead groups; CLA_SUB_EN adds a-b mode.
// Latency: operands register into stage 1 on acceptance, result registers on the following edge.
// Backpressure: full throughput; in_ready falls only when both stages are full and out_ready is low.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_adder_pipe_if.slave    bus
);
    localparam int NG = WIDTH / GROUP;

    generate
        if (GROUP < 2 || GROUP > 8) begin : g_bad_group
            $error("cla_adder_pipe: GROUP must be in 2..8");
        end
        if (WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_width
            $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    // AND of v[lo..hi]; an empty range (lo > hi) yields 1.
    function automatic logic and_range(input logic [WIDTH-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            r = r & v[i];
        end
        return r;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gp;
    logic [NG-1:0]    s1_gg;
    logic             s1_cin;

    logic             s2_load;
    logic             in_xfer;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    gp_in;
    logic [NG-1:0]    gg_in;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum_nxt;
    logic             co_nxt;
    logic             ov_nxt;

    assign s2_load     = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = rst_n && (!s1_valid || s2_load);
    assign in_xfer     = bus.in_valid && bus.in_ready;

`ifdef CLA_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    assign p_in = bus.a ^ b_eff;
    assign g_in = bus.a & b_eff;

    always_comb begin
        gp_in = '0;
        gg_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = and_range(p_in, k*GROUP, k*GROUP + GROUP - 1);
            for (int j = 0; j < GROUP; j++) begin
                gg_in[k] = gg_in[k] |
                           (g_in[k*GROUP + j] & and_range(p_in, k*GROUP + j + 1, k*GROUP + GROUP - 1));
            end
        end
    end

    // Group carries are flat sum-of-products over GP/GG and cin, so no group waits on its neighbour.
    always_comb begin
        gc    = '0;
        c     = '0;
        gc[0] = s1_cin;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = s1_cin & and_range(WIDTH'(s1_gp), 0, k);
            for (int j = 0; j <= k; j++) begin
                gc[k+1] = gc[k+1] | (s1_gg[j] & and_range(WIDTH'(s1_gp), j + 1, k));
            end
        end
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                c[k*GROUP + i] = gc[k] & and_range(s1_p, k*GROUP, k*GROUP + i - 1);
                for (int j = 0; j < i; j++) begin
                    c[k*GROUP + i] = c[k*GROUP + i] |
                                     (s1_g[k*GROUP + j] & and_range(s1_p, k*GROUP + j + 1, k*GROUP + i - 1));
                end
            end
        end
    end

    assign sum_nxt = s1_p ^ c;
    assign co_nxt  = gc[NG];
    assign ov_nxt  = c[WIDTH-1] ^ co_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_p          <= '0;
            s1_g          <= '0;
            s1_gp         <= '0;
            s1_gg         <= '0;
            s1_cin        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_gp    <= gp_in;
                s1_gg    <= gg_in;
                s1_cin   <= cin_eff;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                bus.out_valid <= 1'b1;
                bus.sum       <= sum_nxt;
                bus.carry_out <= co_nxt;
                bus.overflow  <= ov_nxt;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe (WIDTH=16, GROUP=4): directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an integer-arithmetic reference model.
module tb_cla_adder_pipe;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   accepted   = 0;
    int   popped     = 0;
    bit   done       = 1'b0;
    exp_t q[$];

    cla_adder_pipe_if #(.WIDTH(W)) bus ();

    cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        exp_t e;
        int   sa, sb, sr;
        int   ur;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            sr    = sa - sb;
            e.sum = a - b;
            e.co  = (a >= b);
        end else begin
            ur    = int'(a) + int'(b) + int'(cin);
            sr    = sa + sb + int'(cin);
            e.sum = ur[W-1:0];
            e.co  = ur[W];
        end
        e.ov = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented result against the queue head every cycle it is valid,
    // which also checks that held results stay stable; pops only on an output transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_result: out_valid=1 sum=0x%0h with no operation outstanding (t=%0t)", bus.sum, $time);
            end else begin
                chk("sum", 32'(bus.sum), 32'(q[0].sum));
                chk("carry_out", 32'(bus.carry_out), 32'(q[0].co));
                chk("overflow", 32'(bus.overflow), 32'(q[0].ov));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bit ok;
        ok = 1'b0;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef CLA_SUB_EN
        bus.sub = sub;
`endif
        bus.in_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(a, b, cin, sub));
                accepted++;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, a=0x%0h b=0x%0h", a, b);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int w = 0; w < 50 && q.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d results still outstanding, expected 0", q.size());
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int p0;
        int a0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef CLA_SUB_EN
        bus.sub       = 1'b0;
`endif
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_carry_out", 32'(bus.carry_out), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Full carry chain plus latency: stage 1 holds it after the accepting edge,
        // the registered result is valid after the next one.
        bus.out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("lat_after_accept", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_after_next_edge", 32'(bus.out_valid), 32'd1);
        chk("chain_sum", 32'(bus.sum), 32'h0000);
        chk("chain_carry_out", 32'(bus.carry_out), 32'd1);
        drain();

        // Signed overflow and group-propagate paths
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        send(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
        send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
        drain();

        // Backpressure: two accepted, third held until out_ready rises
        bus.out_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                send(16'd1, 16'd1, 1'b0, 1'b0);
                send(16'd2, 16'd2, 1'b0, 1'b0);
                send(16'd3, 16'd3, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_accepted_while_stalled", 32'(accepted - a0), 32'd2);
                chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
                p0 = popped;
                bus.out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("bp_one_per_cycle", 32'(popped - p0), 32'd3);
            end
        join
        drain();

`ifdef CLA_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();
`endif

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        send(16'd10, 16'd20, 1'b0, 1'b0);
        send(16'd30, 16'd40, 1'b1, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        p0 = popped;
        @(negedge clk);
        chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_stale", 32'(popped - p0), 32'd0);

        // Randomized traffic with random output stalls
        a0 = accepted;
        p0 = popped;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic sub_r;
`ifdef CLA_SUB_EN
                    sub_r = 1'($urandom_range(0, 1));
`else
                    sub_r = 1'b0;
`endif
                    send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), sub_r);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        chk("rand_all_completed", 32'(popped - p0), 32'(accepted - a0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
